// File: rtl/sdram_arb_pkg.sv
// sdram_arbiter shared types.
// FSM state and lane constants.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int NPORT_MAX = 8;
  localparam int SD_LANE   = 48;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Arbiter-to-controller bus.
// master = arbiter, slave = sdram controller.
interface sdram_arbiter_if #(
  parameter int AW = 26
);

  logic          sd_sel;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_din;
  logic [1:0]    sd_bs;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_burst;
  logic          sd_ready;
  logic [63:0]   sd_dout;

  modport master (
    output sd_sel, sd_addr, sd_din, sd_bs,
    output sd_rd, sd_wr, sd_burst,
    input  sd_ready, sd_dout
  );

  modport slave (
    input  sd_sel, sd_addr, sd_din, sd_bs,
    input  sd_rd, sd_wr, sd_burst,
    output sd_ready, sd_dout
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// Round-robin picker over ports 1..NPORT-1.
// Search starts at ptr and wraps back to 1.
module sdram_arb_rr #(
  parameter  int NPORT = 4,
  localparam int IW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] p;
  int            pi;

  // walk farthest-first so the nearest hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    p   = '0;
    pi  = 0;
    for (int k = NPORT - 2; k >= 0; k--) begin
      pi = int'(ptr) + k;
      if (pi >= NPORT)
        pi = pi - (NPORT - 1);
      p = IW'(pi);
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port arbiter in front of the sdram controller.
// Port 0 has fixed priority; ports 1.. are round-robin.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int AW    = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NPORT-1:0]           req,
  input  logic [NPORT-1:0][AW-1:0]   req_addr,
  input  logic [NPORT-1:0]           req_wr,
  input  logic [NPORT-1:0]           req_burst,
  input  logic [NPORT-1:0][15:0]     req_din,
  input  logic [NPORT-1:0][1:0]      req_bs,
  output logic [NPORT-1:0]           ack,
  output logic [63:0]                rdata,
  sdram_arbiter_if.master            sd
);

  localparam int IW = $clog2(NPORT);

  if (NPORT < 2 || NPORT > NPORT_MAX) begin : g_chk
    $error("sdram_arbiter: NPORT out of range");
  end

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    rr_idx;
  logic [IW-1:0]    pick;
  logic [NPORT-1:0] rr_gnt;
  logic             is_wr;
  logic             abort;
  logic             take;

  sdram_arb_rr #(.NPORT(NPORT)) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign pick = req[0] ? '0 : rr_idx;
  assign take = en && sd.sd_ready && (req[0] || |rr_gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IW'(1);
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      is_wr       <= 1'b0;
      abort       <= 1'b0;
      sd.sd_sel   <= 1'b0;
      sd.sd_addr  <= '0;
      sd.sd_din   <= '0;
      sd.sd_bs    <= '0;
      sd.sd_rd    <= 1'b0;
      sd.sd_wr    <= 1'b0;
      sd.sd_burst <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: if (take) begin
          gnt         <= pick;
          is_wr       <= req_wr[pick];
          abort       <= 1'b0;
          sd.sd_sel   <= 1'b1;
          sd.sd_addr  <= req_addr[pick];
          sd.sd_din   <= req_din[pick];
          sd.sd_bs    <= req_bs[pick];
          sd.sd_burst <= req_burst[pick] & ~req_wr[pick];
          sd.sd_rd    <= ~req_wr[pick];
          sd.sd_wr    <= req_wr[pick];
          state       <= ISSUE;
        end
        // hold strobes until the controller shows it is busy
        ISSUE: if (!en || !sd.sd_ready) begin
          sd.sd_rd <= 1'b0;
          sd.sd_wr <= 1'b0;
          abort    <= !en;
          state    <= en ? WAIT : DONE;
        end
        WAIT: if (!en || sd.sd_ready) begin
          abort <= !en;
          state <= DONE;
        end
        DONE: begin
          ack[gnt] <= 1'b1;
          if (abort || is_wr || !en)
            rdata <= '0;
          else if (sd.sd_burst)
            rdata <= sd.sd_dout;
          else
            rdata <= {{SD_LANE{1'b0}}, sd.sd_dout[63:SD_LANE]};
          if (gnt != '0)
            ptr <= (gnt == IW'(NPORT - 1)) ? IW'(1) : gnt + IW'(1);
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
